cache_port_arbiter: RTL and testbench

Two-port front end for the cache controller FSM. Accepts read/write requests from two requesters (port 0, port 1), grants the single cache one at a time with round-robin fairness, and sequences the cache handshake (`Run`/`RW` out, `hit`/`Data_Ready` back). Returns read data and completion to the owning port, guards each access with a timeout, and keeps saturating hit/miss statistics.

---
 rtl/cache_port_arbiter.sv | 170 +++++++++++++++++
 tb/tb_cache_port_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/cache_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cache_port_arbiter                                                         |
// | Round-robin two-port front end sequencing the single-cache handshake,      |
// | with per-access timeout and saturating hit/miss statistics.                |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module cache_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          rw0,
    input  logic          rw1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          done0,
    output logic          done1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          err,
    output logic          Run,
    output logic          RW,
    output logic [AW-1:0] c_addr,
    output logic [DW-1:0] c_wdata,
    input  logic [DW-1:0] c_rdata,
    input  logic          hit,
    input  logic          Data_Ready,
    output logic [15:0]   hit_cnt,
    output logic [15:0]   miss_cnt
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam int            TW     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    logic [1:0]    state_q,  state_d;
    logic          owner_q,  owner_d;
    logic          prio_q,   prio_d;
    logic          rw_q,     rw_d;
    logic [AW-1:0] addr_q,   addr_d;
    logic [DW-1:0] wdata_q,  wdata_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;
    logic          err_q,    err_d;
    logic [TW-1:0] timer_q,  timer_d;
    logic [15:0]   hitc_q,   hitc_d;
    logic [15:0]   missc_q,  missc_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            owner_q  <= 1'b0;
            prio_q   <= 1'b0;
            rw_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            err_q    <= 1'b0;
            timer_q  <= '0;
            hitc_q   <= '0;
            missc_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            prio_q   <= prio_d;
            rw_q     <= rw_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            err_q    <= err_d;
            timer_q  <= timer_d;
            hitc_q   <= hitc_d;
            missc_q  <= missc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        prio_d   = prio_q;
        rw_d     = rw_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        err_d    = err_q;
        timer_d  = timer_q;
        hitc_d   = hitc_q;
        missc_d  = missc_q;
        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    // Contention resolves to prio; otherwise the lone requester wins
                    owner_d = (req0 && req1) ? prio_q : req1;
                    rw_d    = owner_d ? rw1    : rw0;
                    addr_d  = owner_d ? addr1  : addr0;
                    wdata_d = owner_d ? wdata1 : wdata0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                timer_d = '0;
                err_d   = 1'b0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Timer is still zero only on the first WAIT cycle
                if (timer_q == '0) begin
                    if (hit) begin
                        if (hitc_q != 16'hFFFF) hitc_d = hitc_q + 16'd1;
                    end else begin
                        if (missc_q != 16'hFFFF) missc_d = missc_q + 16'd1;
                    end
                end
                if (Data_Ready) begin
                    if (!rw_q) begin
                        if (owner_q) rdata1_d = c_rdata;
                        else         rdata0_d = c_rdata;
                    end
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (timer_q == T_LAST) begin
                    if (owner_q) rdata1_d = '0;
                    else         rdata0_d = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                prio_d  = ~owner_q;
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        Run      = (state_q == S_ISSUE);
        gnt0     = (state_q == S_ISSUE) && !owner_q;
        gnt1     = (state_q == S_ISSUE) &&  owner_q;
        done0    = (state_q == S_RESP)  && !owner_q;
        done1    = (state_q == S_RESP)  &&  owner_q;
        err      = (state_q == S_RESP)  &&  err_q;
        RW       = rw_q;
        c_addr   = addr_q;
        c_wdata  = wdata_q;
        rdata0   = rdata0_q;
        rdata1   = rdata1_q;
        hit_cnt  = hitc_q;
        miss_cnt = missc_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_cache_port_arbiter                                                      |
// | Directed cycle-vector table plus hand sequences for multi-cycle corners.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_cache_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1, rw0, rw1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, done0, done1, err, Run, RW;
    logic [31:0] rdata0, rdata1, c_addr, c_wdata, c_rdata;
    logic        hit, Data_Ready;
    logic [15:0] hit_cnt, miss_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cache_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata0(rdata0), .rdata1(rdata1), .err(err),
        .Run(Run), .RW(RW), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_rdata(c_rdata), .hit(hit), .Data_Ready(Data_Ready),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    typedef struct {
        logic        r0, r1, w0, w1;
        logic [31:0] a0, a1, d0, d1;
        logic        h, dr;
        logic [31:0] crd;
        logic [6:0]  e_ctrl;   // {Run,gnt0,gnt1,done0,done1,err,RW}
        logic [31:0] e_addr, e_wd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r0, r1, w0, w1,
                                input logic [31:0] a0, a1, d0, d1,
                                input logic h, dr, input logic [31:0] crd,
                                input logic [6:0] e_ctrl,
                                input logic [31:0] e_addr, e_wd);
        vec_t v;
        v.r0 = r0; v.r1 = r1; v.w0 = w0; v.w1 = w1;
        v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
        v.h = h; v.dr = dr; v.crd = crd;
        v.e_ctrl = e_ctrl; v.e_addr = e_addr; v.e_wd = e_wd;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0 = 0; req1 = 0; rw0 = 0; rw1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        c_rdata = '0; hit = 0; Data_Ready = 0;
    endtask

    task automatic reset_dut();
        idle_inputs();
        reset = 0;
        step();
        step();
        reset = 1;
    endtask

    task automatic wait_run();
        for (int k = 0; k < 6; k++) begin
            step();
            if (Run) break;
        end
        check("run_seen", Run, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic run_seen;
        logic exp_port, last_owner;
        int   ngr, t;

        // Reset held with live requests must keep every output quiet
        idle_inputs();
        reset = 0; req0 = 1; Data_Ready = 1; c_rdata = 32'hFFFF_FFFF;
        repeat (3) step();
        check("rst_ctrl", {Run, gnt0, gnt1, done0, done1, err, RW}, 0);
        check("rst_bus", {c_addr, c_wdata}, 0);
        check("rst_rdata", {rdata0, rdata1}, 0);
        check("rst_cnt", {hit_cnt, miss_cnt}, 0);
        idle_inputs();
        reset = 1;
        run_seen = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            run_seen |= Run;
        end
        check("idle_no_run", run_seen, 0);

        // Read hit on port 0, then write miss on port 1 (Data_Ready 5 cycles after Run)
        tbl.push_back(mk(1,0,0,0, 32'h10,0,0,0,      0,0,32'h0,       7'b1100000, 32'h10, 32'h0));
        tbl.push_back(mk(1,0,0,0, 32'h10,0,0,0,      0,1,32'hDEADBEEF,7'b0000000, 32'h10, 32'h0));
        tbl.push_back(mk(1,0,0,0, 32'h10,0,0,0,      1,1,32'hA5A5A5A5,7'b0001000, 32'h10, 32'h0));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0,           0,0,32'h0,       7'b0000000, 32'h10, 32'h0));
        tbl.push_back(mk(0,1,0,1, 0,32'h20,0,32'h1234, 0,0,32'h0,     7'b1010001, 32'h20, 32'h1234));
        tbl.push_back(mk(0,1,0,1, 0,32'h20,0,32'h1234, 1,1,32'h0,     7'b0000001, 32'h20, 32'h1234));
        tbl.push_back(mk(0,1,0,1, 0,32'h20,0,32'h1234, 0,0,32'h0,     7'b0000001, 32'h20, 32'h1234));
        tbl.push_back(mk(0,1,0,0, 0,32'h99,0,32'h9, 0,0,32'h0,        7'b0000001, 32'h20, 32'h1234));
        tbl.push_back(mk(0,1,0,0, 0,32'h99,0,32'h9, 0,0,32'h0,        7'b0000001, 32'h20, 32'h1234));
        tbl.push_back(mk(0,1,0,0, 0,32'h99,0,32'h9, 0,0,32'h0,        7'b0000001, 32'h20, 32'h1234));
        tbl.push_back(mk(0,1,0,0, 0,32'h99,0,32'h9, 1,1,32'hBAD,      7'b0000101, 32'h20, 32'h1234));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0,           0,0,32'h0,       7'b0000001, 32'h20, 32'h1234));

        foreach (tbl[i]) begin
            req0 = tbl[i].r0; req1 = tbl[i].r1; rw0 = tbl[i].w0; rw1 = tbl[i].w1;
            addr0 = tbl[i].a0; addr1 = tbl[i].a1; wdata0 = tbl[i].d0; wdata1 = tbl[i].d1;
            hit = tbl[i].h; Data_Ready = tbl[i].dr; c_rdata = tbl[i].crd;
            step();
            check($sformatf("vec%0d_ctrl", i), {Run, gnt0, gnt1, done0, done1, err, RW}, tbl[i].e_ctrl);
            check($sformatf("vec%0d_bus", i), {c_addr, c_wdata}, {tbl[i].e_addr, tbl[i].e_wd});
        end
        check("rdata0_hit", rdata0, 32'hA5A5A5A5);
        check("rdata1_write_unchanged", rdata1, 0);
        check("hit_cnt", hit_cnt, 1);
        check("miss_cnt", miss_cnt, 1);

        // Contention: both ports request continuously, grants must alternate from port 0
        reset_dut();
        req0 = 1; req1 = 1; Data_Ready = 1; hit = 1; c_rdata = 32'h11;
        exp_port = 0; last_owner = 0; ngr = 0;
        for (int cyc = 0; cyc < 40 && ngr < 4; cyc++) begin
            step();
            if (gnt0 || gnt1) begin
                check("grant_order", {gnt0, gnt1}, exp_port ? 2'b01 : 2'b10);
                last_owner = exp_port;
                exp_port = ~exp_port;
                ngr++;
            end
            if (done0 || done1)
                check("done_owner", {done0, done1}, last_owner ? 2'b01 : 2'b10);
        end
        check("grant_count", ngr, 4);

        // Timeout: normal read first, then an access that never sees Data_Ready
        reset_dut();
        req0 = 1; addr0 = 32'h40;
        wait_run();
        step();
        Data_Ready = 1; c_rdata = 32'h5555;
        step();
        check("pre_read_done", {done0, err}, 2'b10);
        check("pre_read_data", rdata0, 32'h5555);
        req0 = 0; Data_Ready = 0;
        step();
        req0 = 1;
        wait_run();
        t = 0;
        while (t < 20) begin
            step();
            t++;
            if (done0) break;
        end
        check("timeout_latency", t, 9);
        check("timeout_err", {done0, err}, 2'b11);
        check("timeout_rdata", rdata0, 0);
        req0 = 0;
        step();
        check("err_low_idle", err, 0);
        req0 = 1;
        wait_run();
        step();
        Data_Ready = 1; c_rdata = 32'h77;
        step();
        check("post_timeout_done", {done0, err}, 2'b10);
        check("post_timeout_data", rdata0, 32'h77);
        req0 = 0; Data_Ready = 0;
        step();

        // Reset mid-WAIT drops the access; pending port 1 is granted after release
        reset_dut();
        req1 = 1; addr1 = 32'h80;
        wait_run();
        step();
        #2;
        reset = 0;
        #1;
        check("midrst_ctrl", {Run, gnt0, gnt1, done0, done1, err}, 0);
        check("midrst_addr", c_addr, 0);
        Data_Ready = 1;
        run_seen = 0;
        for (int k = 0; k < 2; k++) begin
            step();
            run_seen |= done1 | Run;
        end
        check("midrst_no_done", run_seen, 0);
        reset = 1;
        wait_run();
        check("midrst_gnt1_first", {gnt0, gnt1}, 2'b01);
        reset = 0;
        req0 = 1;
        step();
        reset = 1;
        wait_run();
        check("midrst_both_gnt0", {gnt0, gnt1}, 2'b10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
